// File: rtl/execute_stage_pkg.sv
// Shared definitions for the EX stage: ALU opcodes (also used by the decoder),
// FSM states and the control bundle carried into EX/MEM.
package execute_stage_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  localparam logic [1:0] FWD_RESULT_W = 2'b01;
  localparam logic [1:0] FWD_ALU_M    = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } exState_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       regWrite;
    logic       memWrite;
    logic       readEnable;
    logic       byteAddress;
    logic [1:0] resultSrc;
  } exCtrl_t;

  function automatic exCtrl_t bubbleCtrl();
    return exCtrl_t'(11'd0);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Single-cycle combinational ALU for the EX stage. MUL is handled by the
// multi-cycle path in execute_stage, so it yields 0 here like unused codes.
module exec_alu
  import execute_stage_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] SrcA,
  input  logic [WORD_SIZE-1:0] SrcB,
  input  logic [3:0]           ALUControl,
  output logic [WORD_SIZE-1:0] Result,
  output logic                 Zero
);

  localparam logic [WORD_SIZE-1:0] ZERO_W = {WORD_SIZE{1'b0}};

  // Operation select
  always_comb begin
    Result = ZERO_W;
    case (ALUControl)
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_XOR: Result = SrcA ^ SrcB;
      ALU_SLT: Result = {{(WORD_SIZE-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLL: Result = SrcA << SrcB[4:0];
      ALU_SRL: Result = SrcA >> SrcB[4:0];
      default: Result = ZERO_W;
    endcase
  end

  // Zero flag for branch resolution
  always_comb begin
    if (Result == ZERO_W) begin
      Zero = 1'b1;
    end else begin
      Zero = 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Pipeline EX stage: forwarding, ALU, branch/jump redirect, multi-cycle MUL
// and the EX/MEM register feeding the memory stage.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int MUL_LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ValidE,
  input  logic                 FlushE,
  input  logic [WORD_SIZE-1:0] RD1E,
  input  logic [WORD_SIZE-1:0] RD2E,
  input  logic [WORD_SIZE-1:0] ImmExtE,
  input  logic [WORD_SIZE-1:0] PCE,
  input  logic [WORD_SIZE-1:0] PCPlus4E,
  input  logic [4:0]           RdE,
  input  logic                 RegWriteE,
  input  logic                 MemWriteE,
  input  logic                 ReadEnableE,
  input  logic                 ByteAddressE,
  input  logic                 ALUSrcE,
  input  logic                 BranchE,
  input  logic                 JumpE,
  input  logic [1:0]           ResultSrcE,
  input  logic [3:0]           ALUControlE,
  input  logic [1:0]           ForwardAE,
  input  logic [1:0]           ForwardBE,
  input  logic [WORD_SIZE-1:0] ResultW,
  input  logic                 MemStall,
  output logic [WORD_SIZE-1:0] ALUResultM,
  output logic [WORD_SIZE-1:0] WriteDataM,
  output logic [WORD_SIZE-1:0] PCPlus4M,
  output logic [4:0]           RdM,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 ReadEnableM,
  output logic                 ByteAddressM,
  output logic [1:0]           ResultSrcM,
  output logic                 StallE,
  output logic                 PCSrcE,
  output logic [WORD_SIZE-1:0] PCTargetE
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);
  localparam logic [WORD_SIZE-1:0] ZERO_W = {WORD_SIZE{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MUL_LATENCY - 1);

  exState_e             state_r;
  logic [CNT_W-1:0]     mulCount_r;
  logic [WORD_SIZE-1:0] mulA_r, mulB_r, mulWd_r, mulPc4_r;
  exCtrl_t              mulCtrl_r, ctrlM_r, ctrlE_s;

  logic [WORD_SIZE-1:0] srcA_s, srcB_s, writeData_s, aluResult_s, mulLow_s;
  logic                 zero_s, effective_s, isMul_s, isIdle_s, countOne_s;

  // Operand forwarding; select 11 falls back to the register file value
  always_comb begin
    case (ForwardAE)
      FWD_RESULT_W: srcA_s = ResultW;
      FWD_ALU_M:    srcA_s = ALUResultM;
      default:      srcA_s = RD1E;
    endcase
    case (ForwardBE)
      FWD_RESULT_W: writeData_s = ResultW;
      FWD_ALU_M:    writeData_s = ALUResultM;
      default:      writeData_s = RD2E;
    endcase
    if (ALUSrcE) begin
      srcB_s = ImmExtE;
    end else begin
      srcB_s = writeData_s;
    end
  end

  exec_alu #(.WORD_SIZE(WORD_SIZE)) uAlu (
    .SrcA       (srcA_s),
    .SrcB       (srcB_s),
    .ALUControl (ALUControlE),
    .Result     (aluResult_s),
    .Zero       (zero_s)
  );

  assign mulLow_s = mulA_r * mulB_r;

  // Issue qualification, stall and redirect
  always_comb begin
    effective_s = ValidE & ~FlushE;
    isMul_s     = (ALUControlE == ALU_MUL);
    isIdle_s    = (state_r == ST_IDLE);
    countOne_s  = (mulCount_r == CNT_ONE);
    ctrlE_s     = '{rd: RdE, regWrite: RegWriteE, memWrite: MemWriteE,
                    readEnable: ReadEnableE, byteAddress: ByteAddressE,
                    resultSrc: ResultSrcE};
    PCTargetE   = PCE + ImmExtE;
    StallE      = MemStall | (isIdle_s & effective_s & isMul_s)
                | (~isIdle_s & ~(countOne_s & ~MemStall));
    PCSrcE      = effective_s & isIdle_s & ~MemStall & ((BranchE & zero_s) | JumpE);
  end

  // FSM, multiply latch and EX/MEM register; MemStall freezes EX/MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mulCount_r <= CNT_ZERO;
      mulA_r     <= ZERO_W;
      mulB_r     <= ZERO_W;
      mulWd_r    <= ZERO_W;
      mulPc4_r   <= ZERO_W;
      mulCtrl_r  <= bubbleCtrl();
      ALUResultM <= ZERO_W;
      WriteDataM <= ZERO_W;
      PCPlus4M   <= ZERO_W;
      ctrlM_r    <= bubbleCtrl();
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!MemStall) begin
            if (effective_s && isMul_s) begin
              mulA_r     <= srcA_s;
              mulB_r     <= srcB_s;
              mulWd_r    <= writeData_s;
              mulPc4_r   <= PCPlus4E;
              mulCtrl_r  <= ctrlE_s;
              mulCount_r <= CNT_START;
              state_r    <= ST_MUL_BUSY;
              ALUResultM <= ZERO_W;
              WriteDataM <= ZERO_W;
              PCPlus4M   <= ZERO_W;
              ctrlM_r    <= bubbleCtrl();
            end else if (effective_s) begin
              ALUResultM <= aluResult_s;
              WriteDataM <= writeData_s;
              PCPlus4M   <= PCPlus4E;
              ctrlM_r    <= ctrlE_s;
            end else begin
              ALUResultM <= ZERO_W;
              WriteDataM <= ZERO_W;
              PCPlus4M   <= ZERO_W;
              ctrlM_r    <= bubbleCtrl();
            end
          end
        end
        ST_MUL_BUSY: begin
          if (!countOne_s) begin
            // early latency cycles elapse even while memory stalls
            mulCount_r <= mulCount_r - CNT_ONE;
            if (!MemStall) begin
              ALUResultM <= ZERO_W;
              WriteDataM <= ZERO_W;
              PCPlus4M   <= ZERO_W;
              ctrlM_r    <= bubbleCtrl();
            end
          end else if (!MemStall) begin
            ALUResultM <= mulLow_s;
            WriteDataM <= mulWd_r;
            PCPlus4M   <= mulPc4_r;
            ctrlM_r    <= mulCtrl_r;
            mulCount_r <= CNT_ZERO;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          mulCount_r <= CNT_ZERO;
        end
      endcase
    end
  end

  assign RdM          = ctrlM_r.rd;
  assign RegWriteM    = ctrlM_r.regWrite;
  assign MemWriteM    = ctrlM_r.memWrite;
  assign ReadEnableM  = ctrlM_r.readEnable;
  assign ByteAddressM = ctrlM_r.byteAddress;
  assign ResultSrcM   = ctrlM_r.resultSrc;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios then random
// stimulus against a cycle-level behavioural model.
module tb_execute_stage;

  localparam int W   = 32;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst, ValidE, FlushE, RegWriteE, MemWriteE, ReadEnableE, ByteAddressE;
  logic ALUSrcE, BranchE, JumpE, MemStall;
  logic [W-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0] RdE;
  logic [1:0] ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0] ALUControlE;
  logic [W-1:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetE;
  logic [4:0] RdM;
  logic RegWriteM, MemWriteM, ReadEnableM, ByteAddressM, StallE, PCSrcE;
  logic [1:0] ResultSrcM;

  execute_stage #(.WORD_SIZE(W), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .FlushE(FlushE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ReadEnableE(ReadEnableE),
    .ByteAddressE(ByteAddressE), .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .MemStall(MemStall),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ReadEnableM(ReadEnableM),
    .ByteAddressM(ByteAddressM), .ResultSrcM(ResultSrcM), .StallE(StallE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE)
  );

  always #5 clk = ~clk;

  int numChecks = 0;
  int numErrors = 0;

  task automatic checkVal(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected EX/MEM contents and outstanding multiply
  logic [W-1:0] mRes, mWd, mPc4;
  logic [4:0]   mRd;
  logic         mRw, mMw, mRe, mBa, mBubble;
  logic [1:0]   mRs;
  bit           busy;
  int           elapsed;
  logic [W-1:0] pRes, pWd, pPc4;
  logic [4:0]   pRd;
  logic         pRw, pMw, pRe, pBa;
  logic [1:0]   pRs;

  logic [W-1:0] srcA, srcB, wd, aluRes;
  bit           eff, isMul;

  function automatic logic [W-1:0] refAlu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] prod;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] fwd(input logic [1:0] sel, input logic [W-1:0] rd);
    if (sel == 2'b01) return ResultW;
    if (sel == 2'b10) return mRes;
    return rd;
  endfunction

  task automatic modelClear();
    mRes = '0; mWd = '0; mPc4 = '0; mRd = '0; mRw = 0; mMw = 0; mRe = 0; mBa = 0; mRs = '0;
  endtask

  task automatic calcE();
    eff    = ValidE && !FlushE;
    isMul  = (ALUControlE == 4'd8);
    srcA   = fwd(ForwardAE, RD1E);
    wd     = fwd(ForwardBE, RD2E);
    srcB   = ALUSrcE ? ImmExtE : wd;
    aluRes = refAlu(ALUControlE, srcA, srcB);
  endtask

  task automatic checkComb();
    bit expStall, expPcSrc;
    #3;
    calcE();
    if (!busy) begin
      expStall = MemStall || (eff && isMul);
      expPcSrc = eff && !MemStall && ((BranchE && aluRes == 0) || JumpE);
    end else begin
      expStall = !(elapsed >= LAT - 1 && !MemStall);
      expPcSrc = 0;
    end
    checkVal("StallE", {31'd0, StallE}, {31'd0, expStall});
    checkVal("PCSrcE", {31'd0, PCSrcE}, {31'd0, expPcSrc});
    checkVal("PCTargetE", PCTargetE, PCE + ImmExtE);
  endtask

  task automatic clockEdge();
    calcE();
    if (rst) begin
      busy = 0; elapsed = 0; modelClear(); mBubble = 0;
    end else if (!busy) begin
      if (!MemStall) begin
        if (eff && isMul) begin
          busy = 1; elapsed = 1;
          pRes = aluRes; pWd = wd; pPc4 = PCPlus4E; pRd = RdE;
          pRw = RegWriteE; pMw = MemWriteE; pRe = ReadEnableE; pBa = ByteAddressE; pRs = ResultSrcE;
          modelClear(); mBubble = 1;
        end else if (eff) begin
          mRes = aluRes; mWd = wd; mPc4 = PCPlus4E; mRd = RdE; mRw = RegWriteE;
          mMw = MemWriteE; mRe = ReadEnableE; mBa = ByteAddressE; mRs = ResultSrcE; mBubble = 0;
        end else begin
          modelClear(); mBubble = 1;
        end
      end
    end else begin
      if (elapsed >= LAT - 1 && !MemStall) begin
        busy = 0;
        mRes = pRes; mWd = pWd; mPc4 = pPc4; mRd = pRd; mRw = pRw;
        mMw = pMw; mRe = pRe; mBa = pBa; mRs = pRs; mBubble = 0;
      end else begin
        elapsed++;
        if (!MemStall) begin modelClear(); mBubble = 1; end
      end
    end
    @(posedge clk);
    #1;
    checkVal("RegWriteM", {31'd0, RegWriteM}, {31'd0, mRw});
    checkVal("MemWriteM", {31'd0, MemWriteM}, {31'd0, mMw});
    checkVal("ReadEnableM", {31'd0, ReadEnableM}, {31'd0, mRe});
    if (!mBubble) begin
      checkVal("ALUResultM", ALUResultM, mRes);
      checkVal("WriteDataM", WriteDataM, mWd);
      checkVal("PCPlus4M", PCPlus4M, mPc4);
      checkVal("RdM", {27'd0, RdM}, {27'd0, mRd});
      checkVal("ByteAddressM", {31'd0, ByteAddressM}, {31'd0, mBa});
      checkVal("ResultSrcM", {30'd0, ResultSrcM}, {30'd0, mRs});
    end
  endtask

  task automatic cycle();
    checkComb();
    clockEdge();
  endtask

  task automatic idleInputs();
    rst = 0; ValidE = 0; FlushE = 0; RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = '0;
    PCPlus4E = '0; RdE = '0; RegWriteE = 0; MemWriteE = 0; ReadEnableE = 0;
    ByteAddressE = 0; ALUSrcE = 0; BranchE = 0; JumpE = 0; ResultSrcE = '0;
    ALUControlE = '0; ForwardAE = '0; ForwardBE = '0; ResultW = '0; MemStall = 0;
  endtask

  task automatic issueMul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd);
    idleInputs();
    ValidE = 1; ALUControlE = 4'd8; RD1E = a; RD2E = b; RegWriteE = 1; RdE = rd;
  endtask

  initial begin
    busy = 0; elapsed = 0; mBubble = 0; modelClear();
    idleInputs();

    // Reset for two cycles
    rst = 1;
    cycle(); cycle();
    rst = 0;
    checkComb();
    checkVal("rst_ALUResultM", ALUResultM, 32'd0);
    checkVal("rst_RegWriteM", {31'd0, RegWriteM}, 32'd0);
    checkVal("rst_StallE", {31'd0, StallE}, 32'd0);
    checkVal("rst_PCSrcE", {31'd0, PCSrcE}, 32'd0);
    clockEdge();

    // ADD with ResultW forwarded into SrcA
    idleInputs();
    ValidE = 1; RD1E = 32'd5; ForwardAE = 2'b01; ResultW = 32'd7; ImmExtE = 32'd3;
    ALUSrcE = 1; ALUControlE = 4'd0; RegWriteE = 1; RdE = 5'd3;
    cycle();
    checkVal("fwd_add", ALUResultM, 32'd10);

    // Taken branch, then the same branch under MemStall
    idleInputs();
    ValidE = 1; RD1E = 32'h20; RD2E = 32'h20; BranchE = 1; PCE = 32'h100;
    ImmExtE = 32'h40; ALUControlE = 4'd1;
    checkComb();
    checkVal("beq_taken", {31'd0, PCSrcE}, 32'd1);
    checkVal("beq_target", PCTargetE, 32'h140);
    clockEdge();
    MemStall = 1;
    checkComb();
    checkVal("beq_memstall", {31'd0, PCSrcE}, 32'd0);
    clockEdge();
    MemStall = 0;

    // MUL latency with no memory stall
    issueMul(32'hFFFF_FFFF, 32'd2, 5'd9);
    for (int i = 0; i < LAT - 1; i++) begin
      checkComb();
      checkVal("mul_stall", {31'd0, StallE}, 32'd1);
      clockEdge();
      checkVal("mul_bubble", {31'd0, RegWriteM}, 32'd0);
    end
    checkComb();
    checkVal("mul_release", {31'd0, StallE}, 32'd0);
    clockEdge();
    checkVal("mul_result", ALUResultM, 32'hFFFF_FFFE);
    checkVal("mul_regwrite", {31'd0, RegWriteM}, 32'd1);
    idleInputs();
    cycle();

    // MUL held three cycles by MemStall on its final cycle
    issueMul(32'd3, 32'd7, 5'd4);
    cycle();
    idleInputs();
    for (int i = 0; i < LAT - 2; i++) cycle();
    MemStall = 1;
    for (int i = 0; i < 3; i++) begin
      checkComb();
      checkVal("mulms_stall", {31'd0, StallE}, 32'd1);
      clockEdge();
      checkVal("mulms_hold", {31'd0, RegWriteM}, 32'd0);
    end
    MemStall = 0;
    cycle();
    checkVal("mulms_result", ALUResultM, 32'd21);
    checkVal("mulms_regwrite", {31'd0, RegWriteM}, 32'd1);
    cycle();
    checkVal("mulms_nodup", {31'd0, RegWriteM}, 32'd0);

    // Flushed store becomes a bubble
    idleInputs();
    ValidE = 1; FlushE = 1; MemWriteE = 1; ALUSrcE = 1; ImmExtE = 32'h10;
    cycle();
    checkVal("flush_sw", {31'd0, MemWriteM}, 32'd0);

    // Reset in the middle of a MUL
    issueMul(32'd11, 32'd13, 5'd2);
    cycle(); cycle();
    idleInputs();
    rst = 1;
    cycle();
    rst = 0;
    checkComb();
    checkVal("rstmul_stall", {31'd0, StallE}, 32'd0);
    checkVal("rstmul_result", ALUResultM, 32'd0);
    checkVal("rstmul_regwrite", {31'd0, RegWriteM}, 32'd0);
    clockEdge();

    // Random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      ValidE       = ($urandom_range(0, 7) != 0);
      FlushE       = ($urandom_range(0, 7) == 0);
      MemStall     = ($urandom_range(0, 3) == 0);
      RD1E         = ($urandom_range(0, 3) == 0) ? RD2E : $urandom;
      RD2E         = $urandom;
      ImmExtE      = $urandom;
      PCE          = $urandom;
      PCPlus4E     = PCE + 32'd4;
      ResultW      = $urandom;
      RdE          = 5'($urandom);
      RegWriteE    = 1'($urandom);
      MemWriteE    = 1'($urandom);
      ReadEnableE  = 1'($urandom);
      ByteAddressE = 1'($urandom);
      ALUSrcE      = 1'($urandom);
      ResultSrcE   = 2'($urandom);
      ALUControlE  = ($urandom_range(0, 5) == 0) ? 4'd8 : 4'($urandom);
      BranchE      = 1'($urandom);
      JumpE        = ($urandom_range(0, 7) == 0);
      ForwardAE    = 2'($urandom);
      ForwardBE    = 2'($urandom);
      if (ALUControlE == 4'd8) begin BranchE = 0; JumpE = 0; end
      if (mBubble && ForwardAE == 2'b10) ForwardAE = 2'b00;
      if (mBubble && ForwardBE == 2'b10) ForwardBE = 2'b00;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline EX stage, directly upstream of the memory stage.
- Takes operands and control from the ID/EX register and resolves forwarding, the ALU op, and branch/jump redirection.
- Runs a multi-cycle multiply and drives the EX/MEM register that feeds the memory stage.
- Honours the memory-side stall (cache/store-buffer) and generates its own stall for multiply.

Parameters:
- WORD_SIZE, 32, datapath width.
- MUL_LATENCY, 5, cycles a MUL occupies EX including its issue cycle; must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ValidE  in  1  ID/EX holds a real instruction
- FlushE  in  1  treat ID/EX contents as a bubble this cycle
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  in  WORD_SIZE each  register operands, immediate, PC, PC+4
- RdE  in  5  destination register
- RegWriteE, MemWriteE, ReadEnableE, ByteAddressE, ALUSrcE, BranchE, JumpE  in  1 each  decoded control
- ResultSrcE  in  2  writeback select
- ALUControlE  in  4  operation
- ForwardAE, ForwardBE  in  2 each  forwarding select: 00 = RDxE, 01 = ResultW, 10 = ALUResultM
- ResultW  in  WORD_SIZE  writeback value
- MemStall  in  1  CacheStall OR SBStall from the memory stage
- ALUResultM, WriteDataM, PCPlus4M  out  WORD_SIZE each  EX/MEM register outputs
- RdM  out  5  EX/MEM destination register
- RegWriteM, MemWriteM, ReadEnableM, ByteAddressM  out  1 each  EX/MEM control
- ResultSrcM  out  2  EX/MEM writeback select
- StallE  out  1  hold PC, IF/ID and ID/EX
- PCSrcE  out  1  redirect fetch
- PCTargetE  out  WORD_SIZE  redirect target

Behaviour:
- Reset: all EX/MEM outputs are 0 (the EX/MEM register holds a bubble); state is IDLE; counter is 0.
- Operands:
  - SrcA = forwardA(RD1E).
  - WriteData = forwardB(RD2E).
  - SrcB = ALUSrcE ? ImmExtE : WriteData.
  - Forward select 11 behaves as 00.
- ALU encodings (ALUControlE): 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLL, 0111 SRL, 1000 MUL; any other code produces 0.
  - Shifts use SrcB[4:0].
  - MUL returns the low WORD_SIZE bits of the product; ADD/SUB wrap modulo 2^WORD_SIZE.
- Branch resolution:
  - ZeroE = (ALU result == 0).
  - PCTargetE = PCE + ImmExtE.
  - PCSrcE = ValidE & !FlushE & state==IDLE & !MemStall & ((BranchE & ZeroE) | JumpE).
- Issue: effective instruction = ValidE & !FlushE. Non-MUL instructions complete in 1 cycle.
- FSM, IDLE state:
  - MemStall=1: EX/MEM holds its value; StallE=1.
  - Effective MUL with MemStall=0:
    - Latch SrcA, SrcB, RdE and the control bits.
    - Counter ← MUL_LATENCY-1; go to MUL_BUSY.
    - StallE=1; EX/MEM ← bubble.
  - Otherwise: EX/MEM ← ALU result, WriteData, PCPlus4E and control. A non-effective instruction loads a bubble (RegWrite, MemWrite and ReadEnable all 0).
- FSM, MUL_BUSY state:
  - StallE=1.
  - Counter > 1: counter decrements every cycle regardless of MemStall; EX/MEM ← bubble if !MemStall, else holds.
  - Counter == 1 and MemStall=1: wait with counter at 1; EX/MEM holds.
  - Counter == 1 and MemStall=0: StallE=0; EX/MEM ← latched product and latched control; go to IDLE.
- MUL timing: with no MemStall, the result appears on ALUResultM MUL_LATENCY clock edges after the issue cycle's edge minus one. For example, with MUL_LATENCY=5, a MUL issued in cycle t is visible in cycle t+5.
- Ignored inputs during MUL_BUSY: FlushE and the forwarding inputs (operands are latched at issue).
- StallE = MemStall | (IDLE & effective MUL) | (MUL_BUSY & !(counter==1 & !MemStall)).
- rst asserted in any state, including mid-MUL, returns to the reset condition at the next edge; the in-flight MUL is discarded.

Decomposition:
- constants.v holds WORD_SIZE and the ALU opcode defines (ALU_ADD … ALU_MUL); the decoder must use the same codes.
- One combinational sub-module, exec_alu (SrcA, SrcB, ALUControl → Result, Zero), excluding MUL.
- The multiplier, counter and FSM stay in execute_stage.

Test Plan:
- Reset: hold rst for 2 cycles → all EX/MEM outputs 0, StallE=0, PCSrcE=0.
- ADD forwarding: RD1E=5, ForwardAE=01 with ResultW=7, ImmExtE=3, ALUSrcE=1, ADD → ALUResultM=10 one edge later.
- Branch taken: BEQ with RD1E=RD2E=0x20, BranchE=1, PCE=0x100, Imm=0x40 → PCSrcE=1, PCTargetE=0x140 in the same cycle. The same case with MemStall=1 → PCSrcE=0.
- MUL latency: MUL 0xFFFFFFFF × 2, MUL_LATENCY=5 → StallE=1 for 4 cycles; ALUResultM=0xFFFFFFFE with RegWriteM=1 after the 5th edge; intervening EX/MEM values are bubbles.
- MUL stalled: MemStall raised for 3 cycles while counter==1 → result delayed exactly 3 cycles, EX/MEM unchanged during the stall, no duplicate write.
- Flush and reset: FlushE=1 with a SW present → MemWriteM=0. rst asserted mid-MUL → next cycle IDLE, StallE=0, outputs 0.
